// File: rtl/reg_file_sb_if.sv
// Register-file bus: two combinational read ports, one write port and the
// load-reservation scoreboard controls.
interface reg_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    localparam int NREGS = 1 << ADDR_W;

    logic [ADDR_W-1:0] rr1;
    logic [ADDR_W-1:0] rr2;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic              regwrite;
    logic              pend_set;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              stall;
    logic [NREGS-1:0]  pending;

    modport master (
        output rr1, rr2, wr, wd, regwrite, pend_set, pend_addr,
        input  rd1, rd2, stall, pending
    );

    modport slave (
        input  rr1, rr2, wr, wd, regwrite, pend_set, pend_addr,
        output rd1, rd2, stall, pending
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with hard-wired zero register, optional write-to-read
// forwarding and a pending-load scoreboard that raises stall on hazards.
module reg_file_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2,
    parameter int BYPASS = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    reg_file_sb_if.slave  bus
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [NREGS-1:0]  pending_reg;
    logic [NREGS-1:0]  pending_next;

    // Register 0 is never written, so it holds zero from reset onward.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (bus.regwrite && (bus.wr != '0)) begin
            regs_reg[bus.wr] <= bus.wd;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_bit
                // A reservation on the same edge as the retiring write wins.
                assign pending_next[gi] =
                    (bus.pend_set && (bus.pend_addr == ADDR_W'(gi))) ||
                    (pending_reg[gi] && !(bus.regwrite && (bus.wr == ADDR_W'(gi))));
            end
        end
    endgenerate

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    logic [ADDR_W-1:0] rr_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [1:0]        hazard;

    assign rr_addr[0] = bus.rr1;
    assign rr_addr[1] = bus.rr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic fwd;
            assign fwd = (BYPASS != 0) && bus.regwrite && (bus.wr != '0) &&
                         (bus.wr == rr_addr[gi]);
            // Outputs are forced quiet while reset is held, even if a write is presented.
            assign rd_data[gi] = (!reset_n || (rr_addr[gi] == '0)) ? '0 :
                                 fwd ? bus.wd : regs_reg[rr_addr[gi]];
            assign hazard[gi]  = pending_reg[rr_addr[gi]] && !fwd;
        end
    endgenerate

    assign bus.rd1     = rd_data[0];
    assign bus.rd2     = rd_data[1];
    assign bus.stall   = reset_n && (|hazard);
    assign bus.pending = pending_reg;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a forwarding and a non-forwarding instance share one
// stimulus stream and are checked against a register/scoreboard model.
module tb_reg_file_sb;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rr1 = '0, rr2 = '0, wr = '0, pend_addr = '0;
    logic [15:0] wd = '0;
    logic        regwrite = 1'b0, pend_set = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    reg_file_sb_if #(.DATA_W(16), .ADDR_W(2)) if1 ();
    reg_file_sb_if #(.DATA_W(16), .ADDR_W(2)) if0 ();

    assign if1.rr1 = rr1;  assign if1.rr2 = rr2;  assign if1.wr = wr;  assign if1.wd = wd;
    assign if1.regwrite = regwrite;  assign if1.pend_set = pend_set;  assign if1.pend_addr = pend_addr;
    assign if0.rr1 = rr1;  assign if0.rr2 = rr2;  assign if0.wr = wr;  assign if0.wd = wd;
    assign if0.regwrite = regwrite;  assign if0.pend_set = pend_set;  assign if0.pend_addr = pend_addr;

    reg_file_sb #(.DATA_W(16), .ADDR_W(2), .BYPASS(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(if1));
    reg_file_sb #(.DATA_W(16), .ADDR_W(2), .BYPASS(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(if0));

    // Model: architectural register contents and the set of outstanding loads.
    logic [15:0] m_regs [4];
    logic [3:0]  m_pend;

    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_pend = '0;
        end else begin
            if (regwrite && wr != 0) begin
                m_regs[wr] = wd;
                m_pend[wr] = 1'b0;
            end
            if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
        end
    end

    function automatic logic [15:0] exp_rd(logic [1:0] rr, bit byp);
        if (!reset_n || rr == 0) return 16'h0;
        if (byp && regwrite && wr == rr) return wd;
        return m_regs[rr];
    endfunction

    function automatic logic exp_stall(bit byp);
        logic h1, h2;
        if (!reset_n) return 1'b0;
        h1 = m_pend[rr1] && !(byp && regwrite && wr == rr1);
        h2 = m_pend[rr2] && !(byp && regwrite && wr == rr2);
        return h1 || h2;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle, well before the falling edge, compare both instances to the model.
    always @(posedge clock) begin
        #3;
        check("cmp_rd1_byp1",   32'(if1.rd1),     32'(exp_rd(rr1, 1'b1)));
        check("cmp_rd2_byp1",   32'(if1.rd2),     32'(exp_rd(rr2, 1'b1)));
        check("cmp_stall_byp1", 32'(if1.stall),   32'(exp_stall(1'b1)));
        check("cmp_pend_byp1",  32'(if1.pending), 32'(m_pend));
        check("cmp_rd1_byp0",   32'(if0.rd1),     32'(exp_rd(rr1, 1'b0)));
        check("cmp_rd2_byp0",   32'(if0.rd2),     32'(exp_rd(rr2, 1'b0)));
        check("cmp_stall_byp0", 32'(if0.stall),   32'(exp_stall(1'b0)));
        check("cmp_pend_byp0",  32'(if0.pending), 32'(m_pend));
    end

    task automatic drive(input logic rw, input logic [1:0] w, input logic [15:0] d,
                         input logic ps, input logic [1:0] pa,
                         input logic [1:0] a1, input logic [1:0] a2);
        @(posedge clock);
        #1;
        regwrite = rw; wr = w; wd = d; pend_set = ps; pend_addr = pa; rr1 = a1; rr2 = a2;
        $display("txn t=%0t rw=%0d wr=%0d wd=%h ps=%0d pa=%0d rr1=%0d rr2=%0d",
                 $time, rw, w, d, ps, pa, a1, a2);
    endtask

    task automatic after_edge();
        @(negedge clock);
        #1;
    endtask

    initial begin
        #100000;
        check("watchdog", 32'd1, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        repeat (2) @(posedge clock);
        #2;
        check("reset_rd1", 32'(if1.rd1), 32'h0);
        check("reset_pending", 32'(if1.pending), 32'h0);
        #1 reset_n = 1'b1;

        // Basic writes then dual read.
        drive(1, 1, 16'h0005, 0, 0, 0, 0);
        drive(1, 2, 16'h0007, 0, 0, 0, 0);
        drive(0, 0, 16'h0000, 0, 0, 1, 2);
        #2;
        check("basic_rd1", 32'(if1.rd1), 32'h5);
        check("basic_rd2", 32'(if1.rd2), 32'h7);
        check("basic_stall", 32'(if1.stall), 32'h0);

        // Writes to register 0 are discarded.
        drive(1, 0, 16'hFFFF, 0, 0, 0, 1);
        #2 check("r0_before", 32'(if1.rd1), 32'h0);
        after_edge();
        check("r0_after", 32'(if1.rd1), 32'h0);

        // Forwarding versus edge-latency write-to-read.
        drive(1, 3, 16'h00AA, 0, 0, 0, 3);
        #2;
        check("byp1_rd2_pre", 32'(if1.rd2), 32'h00AA);
        check("byp0_rd2_pre", 32'(if0.rd2), 32'h0);
        after_edge();
        check("byp0_rd2_post", 32'(if0.rd2), 32'h00AA);

        // Reservation affects stall only from the next cycle; write clears it.
        drive(0, 0, 16'h0000, 1, 2, 2, 0);
        #2 check("pend_same_cycle_stall", 32'(if1.stall), 32'h0);
        drive(0, 0, 16'h0000, 0, 0, 2, 0);
        #2;
        check("pend_stall", 32'(if1.stall), 32'h1);
        check("pend_vec", 32'(if1.pending), 32'h4);
        drive(1, 2, 16'h0009, 0, 0, 2, 0);
        #2;
        check("retire_stall_byp1", 32'(if1.stall), 32'h0);
        check("retire_rd1_byp1", 32'(if1.rd1), 32'h9);
        check("retire_stall_byp0", 32'(if0.stall), 32'h1);
        after_edge();
        check("retire_pend", 32'(if1.pending), 32'h0);
        check("retire_stall_post", 32'(if0.stall), 32'h0);

        // Set beats clear on the same address; data still lands.
        drive(1, 1, 16'h0003, 1, 1, 0, 0);
        after_edge();
        check("setwins_pend", 32'(if1.pending), 32'h2);
        drive(0, 0, 16'h0000, 0, 0, 1, 0);
        #2 check("setwins_rd1", 32'(if0.rd1), 32'h3);

        // Set r2 and clear r3 on one edge.
        drive(0, 0, 16'h0000, 1, 3, 0, 0);
        drive(1, 3, 16'h0011, 1, 2, 0, 0);
        after_edge();
        check("set_clear_pend", 32'(if1.pending), 32'h6);
        drive(0, 0, 16'h0000, 1, 1, 0, 0);
        drive(1, 3, 16'h0022, 0, 0, 0, 0);
        after_edge();
        check("idempotent_pend", 32'(if1.pending), 32'h6);

        // Mid-cycle reset pulse with a write presented during reset.
        drive(1, 1, 16'h0005, 1, 2, 1, 2);
        @(posedge clock);
        #1;
        regwrite = 0; pend_set = 0; rr1 = 1; rr2 = 2;
        check("prereset_rd1", 32'(if1.rd1), 32'h5);
        check("prereset_stall", 32'(if1.stall), 32'h1);
        reset_n = 1'b0;
        regwrite = 1; wr = 1; wd = 16'h0077;
        #1;
        check("reset_rd1_now", 32'(if1.rd1), 32'h0);
        check("reset_pend_now", 32'(if1.pending), 32'h0);
        check("reset_stall_now", 32'(if1.stall), 32'h0);
        #2 reset_n = 1'b1;
        after_edge();
        check("postreset_first_edge", 32'(if0.rd1), 32'h0077);

        // Mixed traffic, checked by the per-cycle compare process.
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom));
        end
        drive(0, 0, 16'h0000, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 16, register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 2, register-address width; NREGS = 2**ADDR_W registers.
REQ-003 Parameter BYPASS, default 1; 1 enables write-to-read forwarding, 0 disables it.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  sole clock; all state updates on its falling edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 rr1  input  ADDR_W  read-port-1 register address.
REQ-008 rr2  input  ADDR_W  read-port-2 register address.
REQ-009 wr  input  ADDR_W  write register address.
REQ-010 wd  input  DATA_W  write data.
REQ-011 regwrite  input  1  write enable; also clears the pending bit of wr.
REQ-012 pend_set  input  1  marks pend_addr as awaiting a load result.
REQ-013 pend_addr  input  ADDR_W  register reserved by an issued load.
REQ-014 rd1  output  DATA_W  read data, port 1, combinational.
REQ-015 rd2  output  DATA_W  read data, port 2, combinational.
REQ-016 stall  output  1  hazard flag, combinational.
REQ-017 pending  output  NREGS  scoreboard vector, registered; bit i is register i.

Function
REQ-018 Register 0 SHALL always read 0; writes and pend_set to address 0 SHALL be ignored; pending[0] SHALL stay 0.
REQ-019 On a falling clock edge with regwrite=1 and wr!=0, reg[wr] SHALL take wd; no other register changes.
REQ-020 rdN SHALL equal reg[rrN], or 0 when rrN=0.
REQ-021 With BYPASS=1, regwrite=1, wr!=0 and wr==rrN, rdN SHALL equal wd in the same cycle, before the edge.
REQ-022 With BYPASS=0, rdN SHALL show the old value until the edge; the new value follows the edge.
REQ-023 Both read ports SHALL be independent; rr1==rr2 SHALL return identical data.
REQ-024 Falling edge with pend_set=1 and pend_addr!=0: pending[pend_addr] SHALL be set to 1.
REQ-025 Falling edge with regwrite=1 and wr!=0: pending[wr] SHALL be cleared to 0.
REQ-026 Same edge, pend_set and regwrite on the same nonzero address: set SHALL win (pending stays 1, data is written).
REQ-027 Same edge, set and clear on different addresses: both SHALL take effect.
REQ-028 A set on an already-pending register SHALL keep it pending; a clear on a non-pending register SHALL have no effect.
REQ-029 Port N is hazardous when pending[rrN]=1, unless BYPASS=1 and regwrite=1 and wr==rrN. The forwarded wd resolves the hazard.
REQ-030 stall SHALL be the OR of the port-1 and port-2 hazards.
REQ-031 stall SHALL NOT depend on pend_set in the same cycle; a new reservation affects stall from the next cycle.
REQ-032 Latency: write-to-read is 0 cycles with BYPASS=1 and 1 edge with BYPASS=0; pend_set to stall is 1 edge.

Reset
REQ-033 reset_n=0 SHALL immediately clear all registers and pending bits, independent of clock.
REQ-034 During reset, rd1=rd2=0, stall=0 and pending=0; writes and sets SHALL be ignored.
REQ-035 Reset asserted mid-operation SHALL discard all pending reservations and data.
REQ-036 After reset_n rises, the first falling edge SHALL operate normally.

Verification
REQ-037 Reset, then write 16'h0005 to r1 and 16'h0007 to r2; rr1=1, rr2=2 -> rd1=5, rd2=7, stall=0.
REQ-038 regwrite=1, wr=0, wd=16'hFFFF; rr1=0 -> rd1=0 before and after the edge.
REQ-039 BYPASS=1, r3=0; regwrite=1, wr=3, wd=16'h00AA, rr2=3 -> rd2=16'h00AA before the edge. With BYPASS=0 -> rd2=0 before the edge, 16'h00AA after.
REQ-040 pend_set, pend_addr=2; next cycle rr1=2 -> stall=1, pending=4'b0100. Then regwrite, wr=2, wd=9 -> stall=0 same cycle; pending=0 after the edge.
REQ-041 Same edge: pend_set=1, pend_addr=1, regwrite=1, wr=1, wd=3 -> reg1=3 and pending[1]=1. Separately: set r2 and clear r3 on one edge -> both take effect.
REQ-042 Load r1=5 and set pending[2]; pulse reset_n low between clock edges -> rd1=0, pending=0, stall=0 immediately.
